// File: rtl/mag_pkg.sv
// ============================================================================
// mag_pkg : shared types and elaboration helpers for the sequential comparator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Operands must split into a whole, non-zero number of slices.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mag_chunk.sv
// ============================================================================
// mag_chunk : combinational CHUNK-bit unsigned magnitude compare
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mag_chunk
  import mag_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output cmp_res_t         res
);

  always_comb begin
    res.gt = (a > b);
    res.eq = (a == b);
    res.lt = (a < b);
  end

endmodule

`default_nettype wire

// File: rtl/mag_cmp_seq.sv
// ============================================================================
// mag_cmp_seq : multi-cycle MSB-first magnitude comparator with early exit.
// Optional feature macro: MAG_CMP_SIGNED_EN (adds signed_cmp port).
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mag_cmp_seq
  import mag_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gti,
  input  logic             eqi,
  input  logic             lti,
`ifdef MAG_CMP_SIGNED_EN
  input  logic             signed_cmp,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gto,
  output logic             eqo,
  output logic             lto,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("mag_cmp_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             gti_q, eqi_q, lti_q;
  logic [IDXW-1:0]  idx;
  cmp_res_t         flags, slice_res, cascade_res;
  logic [CHUNK-1:0] a_sl, b_sl, a_cmp, b_cmp;
  logic             accept;

  assign start_ready = ~reset & ((state == IDLE) | ((state == DONE) & res_ready));
  assign accept      = start_valid & start_ready;
  assign res_valid   = (state == DONE);
  assign busy        = (state == RUN);
  assign gto         = flags.gt;
  assign eqo         = flags.eq;
  assign lto         = flags.lt;

  always_comb begin
    a_sl = a_q[int'(idx)*CHUNK +: CHUNK];
    b_sl = b_q[int'(idx)*CHUNK +: CHUNK];
  end

`ifdef MAG_CMP_SIGNED_EN
  logic signed_q;
  logic flip;

  always_ff @(posedge sys_clk) begin
    if (reset)       signed_q <= 1'b0;
    else if (accept) signed_q <= signed_cmp;
  end

  // Two's-complement order equals unsigned order once the sign bits are flipped.
  assign flip  = signed_q & (idx == TOP_IDX);
  assign a_cmp = a_sl ^ (CHUNK'(flip) << (CHUNK - 1));
  assign b_cmp = b_sl ^ (CHUNK'(flip) << (CHUNK - 1));
`else
  assign a_cmp = a_sl;
  assign b_cmp = b_sl;
`endif

  mag_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a  (a_cmp),
    .b  (b_cmp),
    .res(slice_res)
  );

  // Illegal cascade combinations pass through unchecked.
  always_comb begin
    cascade_res.eq = eqi_q;
    cascade_res.gt = ~eqi_q & ~lti_q;
    cascade_res.lt = ~eqi_q & ~gti_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      flags <= '0;
      a_q   <= '0;
      b_q   <= '0;
      gti_q <= 1'b0;
      eqi_q <= 1'b0;
      lti_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      gti_q <= gti;
      eqi_q <= eqi;
      lti_q <= lti;
      idx   <= TOP_IDX;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (!slice_res.eq) begin
            flags <= slice_res;
            state <= DONE;
          end else if (idx == '0) begin
            flags <= cascade_res;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mag_cmp_seq.sv
// ============================================================================
// tb_mag_cmp_seq : directed scoreboard bench for mag_cmp_seq (WIDTH=32, CHUNK=4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mag_cmp_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a, b;
  logic             gti, eqi, lti;
  logic             signed_cmp;
  logic             res_valid;
  logic             res_ready;
  logic             gto, eqo, lto, busy;

  typedef struct {
    logic [2:0] res;   // {gt, eq, lt}
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  mag_cmp_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .gti        (gti),
    .eqi        (eqi),
    .lti        (lti),
`ifdef MAG_CMP_SIGNED_EN
    .signed_cmp (signed_cmp),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .gto        (gto),
    .eqo        (eqo),
    .lto        (lto),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for acceptance and pushes the expectation.
  task automatic send(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic g, input logic e, input logic l, input logic s,
                      input logic [2:0] exp_res, input int exp_lat);
    exp_t x;
    int   w;
    a = va; b = vb; gti = g; eqi = e; lti = l; signed_cmp = s;
    start_valid = 1'b1;
    w = 0;
    while (!start_ready && w < 40) begin
      tick();
      w++;
    end
    if (!start_ready) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    tick();
    start_valid = 1'b0;
    x.res = exp_res; x.lat = exp_lat; x.tag = tag;
    sb.push_back(x);
    cyc = 1;
  endtask

  task automatic collect();
    exp_t x;
    while (!res_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    x = sb.pop_front();
    chk({x.tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({x.tag, "_flags"}, 32'({gto, eqo, lto}), 32'(x.res));
    chk({x.tag, "_latency"}, 32'(cyc), 32'(x.lat));
  endtask

  // Reference: flags and latency from the highest differing slice.
  task automatic model(input logic [31:0] va, input logic [31:0] vb,
                       input logic g, input logic e, input logic l,
                       output logic [2:0] r, output int lat);
    logic [31:0] d;
    int          hb;
    d  = va ^ vb;
    hb = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) hb = i;
    if (hb < 0) begin
      r   = {~e & ~l, e, ~e & ~g};
      lat = NCHUNK + 1;
    end else begin
      r   = {va > vb, 1'b0, va < vb};
      lat = (NCHUNK - hb / CHUNK) + 1;
    end
  endtask

  initial begin
    logic [2:0]  r;
    int          lat;
    logic [31:0] ra, rb;
    logic        seen;

    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
    a = '0; b = '0; gti = 1'b0; eqi = 1'b1; lti = 1'b0; signed_cmp = 1'b0;
    tick();
    tick();
    chk("rst_start_ready_low", 32'(start_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_outputs", 32'({res_valid, gto, eqo, lto, busy}), 32'd0);
    chk("rst_start_ready_high", 32'(start_ready), 32'd1);

    send("msb_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 2);
    chk("busy_in_run", 32'(busy), 32'd1);
    chk("no_accept_in_run", 32'(start_ready), 32'd0);
    collect();
`ifdef MAG_CMP_SIGNED_EN
    tick();
    send("msb_signed", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2);
    collect();
`endif
    tick();
    send("eq_cascade_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 9);
    collect();
    tick();
    send("eq_cascade_gt", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 9);
    collect();
    tick();
    send("eq_cascade_illegal", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 9);
    collect();
    tick();
    send("last_slice_gt", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 9);
    collect();
    tick();
    send("last_slice_lt", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 9);
    collect();
    tick();
    send("second_slice_lt", 32'h0A00_0000, 32'h0B00_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3);
    collect();

    for (int i = 0; i < 6; i++) begin
      tick();
      ra = $urandom;
      rb = ra ^ (32'h1 << $urandom_range(31, 0));
      model(ra, rb, 1'b0, 1'b1, 1'b0, r, lat);
      send("rand", ra, rb, 1'b0, 1'b1, 1'b0, 1'b0, r, lat);
      collect();
    end

    // Back-to-back: second request accepted in the DONE cycle of the first.
    tick();
    send("b2b_first", 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 7);
    collect();
    chk("b2b_ready_in_done", 32'(start_ready), 32'd1);
    send("b2b_second", 32'h9000_0000, 32'h1000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 2);
    chk("b2b_went_run", 32'({busy, res_valid}), 32'b10);
    collect();

    // Result held while consumer stalls.
    tick();
    res_ready = 1'b0;
    send("hold", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 8);
    collect();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_flags", 32'({gto, eqo, lto}), 32'b001);
      chk("hold_start_ready", 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    chk("hold_released", 32'({res_valid, start_ready}), 32'b01);

    // Reset mid-compare discards the in-flight request.
    a = 32'h1234_5678; b = 32'h1234_5678; gti = 1'b0; eqi = 1'b1; lti = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_start_ready_low", 32'(start_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_outputs", 32'({res_valid, gto, eqo, lto, busy}), 32'd0);
    chk("post_rst_start_ready", 32'(start_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("post_rst_no_result", 32'(seen), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mag_cmp_seq.md
# mag_cmp_seq

Parametrised, multi-cycle magnitude comparator. It generalises the 4-bit cascadable comparator to WIDTH-bit operands. Operands are captured on a valid/ready handshake and resolved MSB-first, one CHUNK-bit slice per cycle, stopping early on the first unequal slice. It sits beside the object-processor and blitter compare paths, where wide compares tolerate multi-cycle latency and save area.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 4, slice width compared per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK must be at least 1.

Ports:
- sys_clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_valid  in  1  request valid.
- start_ready  out  1  request accepted when start_valid and start_ready are both high.
- a, b  in  WIDTH  operands; sampled only on accept.
- gti, eqi, lti  in  1 each  cascade inputs; sampled on accept.
- signed_cmp  in  1  two's-complement compare; present only with MAG_CMP_SIGNED_EN, sampled on accept.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid and res_ready are both high.
- gto, eqo, lto  out  1 each  result flags; stable while res_valid is high.
- busy  out  1  high in RUN.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- start_ready = (state==IDLE) | (state==DONE & res_ready). This allows back-to-back requests.
- On accept:
  - a, b, the cascade inputs and signed_cmp are registered.
  - idx is set to NCHUNK-1.
  - The state goes to RUN.
- In RUN, each cycle compares slice idx of the registered a and b as unsigned values.
  - Unequal slice: latch gto = (a_slice > b_slice), lto = the inverse, eqo = 0. Go to DONE.
  - Equal slice with idx > 0: decrement idx and stay in RUN.
  - Equal slice with idx == 0: go to DONE with the cascade result:
    - eqo = eqi
    - gto = ~eqi & ~lti
    - lto = ~eqi & ~gti
- Signed mode: the MSB of slice NCHUNK-1 is inverted in both operands before comparison. No other slice changes.
- DONE holds res_valid and the flags until res_ready.
  - With res_ready high and no new accept, go to IDLE.
  - With res_ready high and a new accept in the same cycle, go straight to RUN.
- The operand registers are not modified during RUN. A new request is never accepted while in RUN.
- Cascade inputs are sampled as given. An illegal combination is not checked (for example gti=lti=1 with eqi=0 gives gto=lto=0).

## Timing
- Reset value of every output:
  - start_ready = 0 during the reset cycle and 1 from the first cycle after.
  - res_valid = 0, gto = eqo = lto = 0, busy = 0.
  - State is IDLE.
- Accept in cycle T: slice NCHUNK-1 is evaluated in T+1.
- If the first unequal slice is the k-th evaluated (k = 1..NCHUNK), res_valid rises at T+1+k.
- All slices equal: res_valid rises at T+1+NCHUNK.
- Minimum latency is 2 cycles and maximum is NCHUNK+1. Throughput is one result per (latency) cycles with res_ready held high.
- res_valid must not depend combinationally on res_ready. start_ready may depend combinationally on res_ready.
- reset asserted in any state, including mid-RUN or during DONE: the next cycle is IDLE and the in-flight result is discarded. No res_valid is produced for it.
- Flags change only on the edge that enters DONE.

## Configuration
- MAG_CMP_SIGNED_EN defined:
  - The signed_cmp port exists.
  - When it is captured high, the top slice MSB inversion is applied.
- MAG_CMP_SIGNED_EN undefined:
  - The port is absent and the compare is always unsigned.
  - No inversion logic is generated.

## Structure
- Shared package mag_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - a packed result struct {gt, eq, lt};
  - the elaboration check function that WIDTH % CHUNK == 0.
- Sub-module mag_chunk: a combinational CHUNK-bit unsigned compare producing gt/eq/lt. It is instantiated once and fed by a slice mux indexed by idx.
- The idx counter width is $clog2(NCHUNK), with a minimum of 1.

## Test plan
- WIDTH=32, CHUNK=4.
  - a=0x80000000, b=0x7FFFFFFF, unsigned, accept at T: gto=1, eqo=0, lto=0, res_valid at T+2.
  - Same operands with signed_cmp=1 (macro defined): lto=1, gto=0, latency 2.
- a=b=0x12345678:
  - with eqi=1, gti=lti=0: eqo=1, gto=lto=0, res_valid at T+9;
  - with eqi=0, gti=1: gto=1, eqo=0, lto=0.
- a=0x0000_0005, b=0x0000_0003: the decision is on the last slice, gto=1, res_valid at T+9.
- Back-to-back:
  - res_ready held 1, second request presented while the first is in DONE: it is accepted in the same cycle and the second result is correct.
  - res_ready held 0 for 5 cycles: the flags stay stable and start_ready stays 0.
- reset pulsed at T+3 during a 9-cycle compare: res_valid never rises for that request. The outputs are zero and start_ready=1 from the cycle after reset.
